// File: rtl/spi_sclk_engine_if.sv
// Handshake/bus bundle between an SPI controller and spi_sclk_engine.
// The CS-related signals exist only when SPI_CLK_CS_EN is defined.
interface spi_sclk_engine_if #(
   parameter int unsigned DIV_W = 16,
   parameter int unsigned LEN_W = 6
);
   logic             i_start;
   logic             i_cpol;
   logic             i_cpha;
   logic [DIV_W-1:0] i_divider;
   logic [LEN_W-1:0] i_len;
   logic             o_sclk;
   logic             o_busy;
   logic             o_launch;
   logic             o_sample;
   logic             o_first;
   logic             o_last;
   logic             o_done;
`ifdef SPI_CLK_CS_EN
   logic [3:0]       i_csdly;
   logic             o_cs_n;

   modport master (
      output i_start, i_cpol, i_cpha, i_divider, i_len, i_csdly,
      input  o_sclk, o_busy, o_launch, o_sample, o_first, o_last, o_done, o_cs_n
   );
   modport slave (
      input  i_start, i_cpol, i_cpha, i_divider, i_len, i_csdly,
      output o_sclk, o_busy, o_launch, o_sample, o_first, o_last, o_done, o_cs_n
   );
`else
   modport master (
      output i_start, i_cpol, i_cpha, i_divider, i_len,
      input  o_sclk, o_busy, o_launch, o_sample, o_first, o_last, o_done
   );
   modport slave (
      input  i_start, i_cpol, i_cpha, i_divider, i_len,
      output o_sclk, o_busy, o_launch, o_sample, o_first, o_last, o_done
   );
`endif
endinterface

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: SCLK for all CPOL/CPHA modes, launch/sample strobes, start/busy/done.
// Define SPI_CLK_CS_EN to add chip select with programmable setup/hold (i_csdly half-periods).
module spi_sclk_engine #(
   parameter int unsigned DIV_W = 16,
   parameter int unsigned LEN_W = 6
) (
   input logic           i_clk,
   input logic           i_rst_n,
   spi_sclk_engine_if.slave bus
);
   localparam int unsigned KW = LEN_W + 1;

   typedef enum logic [1:0] {StIdle, StSetup, StRun, StHold} state_e;

   state_e           state_q, state_d;
   logic             cpha_q, cpha_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [KW-1:0]    k_q, k_d;
   logic [3:0]       hp_q, hp_d;
   logic             sclk_q, sclk_d;
   logic             busy_q, busy_d;
   logic             launch_q, launch_d;
   logic             sample_q, sample_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             done_q, done_d;
   logic [3:0]       guard_hp;

`ifdef SPI_CLK_CS_EN
   logic [3:0]       csdly_q, csdly_d;
   logic             cs_n_q, cs_n_d;
   assign guard_hp = csdly_q;
`else
   assign guard_hp = 4'd0;
`endif

   logic          wrap;
   logic          fire;
   logic [KW-1:0] k_last;
   logic          e_launch, e_sample, e_first, e_last;

   assign wrap   = (cnt_q == div_q);
   assign k_last = {len_q, 1'b1};
   // An SCLK edge fires on the final wrap of setup and on every wrap in run.
   assign fire   = wrap && (((state_q == StSetup) && (hp_q == guard_hp)) || (state_q == StRun));

   always_comb begin
      e_launch = 1'b0;
      e_sample = 1'b0;
      e_first  = 1'b0;
      e_last   = 1'b0;
      if (cpha_q) begin
         e_launch = ~k_q[0];
         e_first  = (k_q == '0);
         e_sample = k_q[0];
         e_last   = (k_q == k_last);
      end else begin
         e_sample = ~k_q[0];
         e_launch = k_q[0] && (k_q != k_last);
         e_last   = (k_q == {len_q, 1'b0});
      end
   end

   always_comb begin
      state_d  = state_q;
      cpha_d   = cpha_q;
      div_d    = div_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      hp_d     = hp_q;
      sclk_d   = sclk_q;
      busy_d   = busy_q;
      launch_d = 1'b0;
      sample_d = 1'b0;
      first_d  = 1'b0;
      last_d   = 1'b0;
      done_d   = 1'b0;
`ifdef SPI_CLK_CS_EN
      csdly_d  = csdly_q;
      cs_n_d   = cs_n_q;
`endif

      if (state_q != StIdle) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end

      if (fire) begin
         sclk_d   = ~sclk_q;
         launch_d = e_launch;
         sample_d = e_sample;
         first_d  = e_launch && e_first;
         last_d   = e_sample && e_last;
         k_d      = k_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            // The SCLK register itself carries the latched CPOL through the transfer.
            sclk_d = bus.i_cpol;
            if (bus.i_start) begin
               cpha_d   = bus.i_cpha;
               div_d    = bus.i_divider;
               len_d    = bus.i_len;
               cnt_d    = '0;
               k_d      = '0;
               hp_d     = '0;
               busy_d   = 1'b1;
               launch_d = ~bus.i_cpha;
               first_d  = ~bus.i_cpha;
               state_d  = StSetup;
`ifdef SPI_CLK_CS_EN
               csdly_d  = bus.i_csdly;
               cs_n_d   = 1'b0;
`endif
            end
         end
         StSetup: begin
            if (fire) begin
               state_d = StRun;
            end else if (wrap) begin
               hp_d = hp_q + 1'b1;
            end
         end
         StRun: begin
            if (fire && (k_q == k_last)) begin
               hp_d    = '0;
               state_d = StHold;
            end
         end
         StHold: begin
            if (done_q) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (wrap) begin
               if (hp_q == guard_hp) begin
                  done_d = 1'b1;
`ifdef SPI_CLK_CS_EN
                  cs_n_d = 1'b1;
`endif
               end else begin
                  hp_d = hp_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         cpha_q   <= 1'b0;
         div_q    <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         k_q      <= '0;
         hp_q     <= '0;
         sclk_q   <= 1'b0;
         busy_q   <= 1'b0;
         launch_q <= 1'b0;
         sample_q <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SPI_CLK_CS_EN
         csdly_q  <= '0;
         cs_n_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cpha_q   <= cpha_d;
         div_q    <= div_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         hp_q     <= hp_d;
         sclk_q   <= sclk_d;
         busy_q   <= busy_d;
         launch_q <= launch_d;
         sample_q <= sample_d;
         first_q  <= first_d;
         last_q   <= last_d;
         done_q   <= done_d;
`ifdef SPI_CLK_CS_EN
         csdly_q  <= csdly_d;
         cs_n_q   <= cs_n_d;
`endif
      end
   end

   assign bus.o_sclk   = sclk_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_launch = launch_q;
   assign bus.o_sample = sample_q;
   assign bus.o_first  = first_q;
   assign bus.o_last   = last_q;
   assign bus.o_done   = done_q;
`ifdef SPI_CLK_CS_EN
   assign bus.o_cs_n   = cs_n_q;
`endif

endmodule
